// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard request bundle and the stall/forward decisions returned for it.
// master: pipeline control side; slave: hazard_scoreboard.
interface hazard_scoreboard_if;
    logic [4:0] rs_D;
    logic [4:0] rt_D;
    logic [1:0] t_use_rs_D;
    logic [1:0] t_use_rt_D;
    logic [4:0] wa_D;
    logic [1:0] t_new_D;
    logic       regwrite_D;
    logic       stall;
    logic       flush_E;
    logic [1:0] fwd_rs_D;
    logic [1:0] fwd_rt_D;
    logic [1:0] fwd_rs_E;
    logic [1:0] fwd_rt_E;

    modport master (
        output rs_D, rt_D, t_use_rs_D, t_use_rt_D, wa_D, t_new_D, regwrite_D,
        input  stall, flush_E, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E
    );

    modport slave (
        input  rs_D, rt_D, t_use_rs_D, t_use_rt_D, wa_D, t_new_D, regwrite_D,
        output stall, flush_E, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard unit: shadows the E/M/W destination records and derives the
// D-stage stall, E-stage flush and D/E forwarding selects from them.
module hazard_scoreboard (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave hz
);

    logic       r_e_we, r_m_we, r_w_we;
    logic [4:0] r_e_wa, r_m_wa, r_w_wa;
    logic [1:0] r_e_tnew, r_m_tnew, r_w_tnew;
    logic [4:0] r_e_rs, r_e_rt;

    logic       w_e_rs_d, w_m_rs_d, w_w_rs_d;
    logic       w_e_rt_d, w_m_rt_d, w_w_rt_d;
    logic       w_m_rs_e, w_w_rs_e, w_m_rt_e, w_w_rt_e;
    logic       w_stall_rs, w_stall_rt, w_stall;

    function automatic logic [1:0] dec_sat(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // $0 is hardwired, so a record naming it never matches.
    function automatic logic match(input logic we, input logic [4:0] wa, input logic [4:0] r);
        return we && (wa == r) && (r != 5'd0);
    endfunction

    // Nearest matching stage decides; a producer not yet ready yields 00 and relies on stall.
    function automatic logic [1:0] fwd_d(input logic me, input logic mm, input logic mw,
                                         input logic [1:0] te, input logic [1:0] tm);
        if (me)      return (te == 2'd0) ? 2'b01 : 2'b00;
        else if (mm) return (tm == 2'd0) ? 2'b10 : 2'b00;
        else if (mw) return 2'b11;
        else         return 2'b00;
    endfunction

    function automatic logic [1:0] fwd_e(input logic mm, input logic mw, input logic [1:0] tm);
        if (mm)      return (tm == 2'd0) ? 2'b10 : 2'b00;
        else if (mw) return 2'b11;
        else         return 2'b00;
    endfunction

    assign w_e_rs_d = match(r_e_we, r_e_wa, hz.rs_D);
    assign w_m_rs_d = match(r_m_we, r_m_wa, hz.rs_D);
    assign w_w_rs_d = match(r_w_we, r_w_wa, hz.rs_D);
    assign w_e_rt_d = match(r_e_we, r_e_wa, hz.rt_D);
    assign w_m_rt_d = match(r_m_we, r_m_wa, hz.rt_D);
    assign w_w_rt_d = match(r_w_we, r_w_wa, hz.rt_D);
    assign w_m_rs_e = match(r_m_we, r_m_wa, r_e_rs);
    assign w_w_rs_e = match(r_w_we, r_w_wa, r_e_rs);
    assign w_m_rt_e = match(r_m_we, r_m_wa, r_e_rt);
    assign w_w_rt_e = match(r_w_we, r_w_wa, r_e_rt);

    always_comb begin
        w_stall_rs = 1'b0;
        w_stall_rt = 1'b0;
        if (hz.t_use_rs_D != 2'd3) begin
            w_stall_rs = (w_e_rs_d && (r_e_tnew > hz.t_use_rs_D)) ||
                         (w_m_rs_d && (r_m_tnew > hz.t_use_rs_D));
        end
        if (hz.t_use_rt_D != 2'd3) begin
            w_stall_rt = (w_e_rt_d && (r_e_tnew > hz.t_use_rt_D)) ||
                         (w_m_rt_d && (r_m_tnew > hz.t_use_rt_D));
        end
        w_stall = w_stall_rs || w_stall_rt;
    end

    assign hz.stall    = w_stall;
    assign hz.flush_E  = w_stall;
    assign hz.fwd_rs_D = fwd_d(w_e_rs_d, w_m_rs_d, w_w_rs_d, r_e_tnew, r_m_tnew);
    assign hz.fwd_rt_D = fwd_d(w_e_rt_d, w_m_rt_d, w_w_rt_d, r_e_tnew, r_m_tnew);
    assign hz.fwd_rs_E = fwd_e(w_m_rs_e, w_w_rs_e, r_m_tnew);
    assign hz.fwd_rt_E = fwd_e(w_m_rt_e, w_w_rt_e, r_m_tnew);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_e_we   <= 1'b0;
            r_e_wa   <= 5'd0;
            r_e_tnew <= 2'd0;
            r_e_rs   <= 5'd0;
            r_e_rt   <= 5'd0;
            r_m_we   <= 1'b0;
            r_m_wa   <= 5'd0;
            r_m_tnew <= 2'd0;
            r_w_we   <= 1'b0;
            r_w_wa   <= 5'd0;
            r_w_tnew <= 2'd0;
        end else begin
            r_w_we   <= r_m_we;
            r_w_wa   <= r_m_wa;
            r_w_tnew <= dec_sat(r_m_tnew);
            r_m_we   <= r_e_we;
            r_m_wa   <= r_e_wa;
            r_m_tnew <= dec_sat(r_e_tnew);
            // A stalled D instruction is replayed next cycle; E gets a bubble meanwhile.
            if (w_stall) begin
                r_e_we   <= 1'b0;
                r_e_wa   <= 5'd0;
                r_e_tnew <= 2'd0;
                r_e_rs   <= 5'd0;
                r_e_rt   <= 5'd0;
            end else begin
                r_e_we   <= hz.regwrite_D;
                r_e_wa   <= hz.wa_D;
                r_e_tnew <= hz.t_new_D;
                r_e_rs   <= hz.rs_D;
                r_e_rt   <= hz.rt_D;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: hand-computed stall/forward expectations
// for load-use, ALU-use, jal/jr, $0 and reset scenarios.
module tb_hazard_scoreboard;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    hazard_scoreboard_if bus ();

    hazard_scoreboard dut (
        .clk   (clk),
        .reset (reset),
        .hz    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic st, input logic [1:0] frs_d,
                              input logic [1:0] frt_d, input logic [1:0] frs_e,
                              input logic [1:0] frt_e);
        check({tag, ".stall"},    32'(bus.stall),    32'(st));
        check({tag, ".flush_E"},  32'(bus.flush_E),  32'(st));
        check({tag, ".fwd_rs_D"}, 32'(bus.fwd_rs_D), 32'(frs_d));
        check({tag, ".fwd_rt_D"}, 32'(bus.fwd_rt_D), 32'(frt_d));
        check({tag, ".fwd_rs_E"}, 32'(bus.fwd_rs_E), 32'(frs_e));
        check({tag, ".fwd_rt_E"}, 32'(bus.fwd_rt_E), 32'(frt_e));
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [1:0] tnew,
                         input logic [4:0] rs, input logic [1:0] turs,
                         input logic [4:0] rt, input logic [1:0] turt);
        bus.regwrite_D = we;
        bus.wa_D       = wa;
        bus.t_new_D    = tnew;
        bus.rs_D       = rs;
        bus.t_use_rs_D = turs;
        bus.rt_D       = rt;
        bus.t_use_rt_D = turt;
        #1;
    endtask

    task automatic bubble();
        drive(1'b0, 5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bubble();
        repeat (3) step();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        bubble();

        // Reset held with random D traffic: nothing may be captured or reported.
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 5'($urandom), 2'($urandom_range(0, 2)), 5'($urandom),
                  2'($urandom), 5'($urandom), 2'($urandom));
            check_outs("rst_hold", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
            step();
        end
        reset = 1'b1;
        bubble();
        check_outs("rst_rel0", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        step();
        check_outs("rst_rel1", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);

        // lw $8 ; add rs=8 (t_use 1): one stall, then W forward in E.
        drain();
        drive(1'b1, 5'd8, 2'd2, 5'd29, 2'd3, 5'd0, 2'd3);
        check_outs("lw_acc", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        step();
        drive(1'b1, 5'd10, 2'd1, 5'd8, 2'd1, 5'd0, 2'd3);
        check_outs("lwuse_c1", 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
        step();
        check_outs("lwuse_c2", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        step();
        bubble();
        check_outs("lwuse_c3", 1'b0, 2'b00, 2'b00, 2'b11, 2'b00);

        // add $9 ; beq $9,$9 (t_use 0): one stall, then M forward on both operands.
        drain();
        drive(1'b1, 5'd9, 2'd1, 5'd1, 2'd1, 5'd2, 2'd1);
        step();
        drive(1'b0, 5'd0, 2'd0, 5'd9, 2'd0, 5'd9, 2'd0);
        check_outs("beq_c1", 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
        step();
        check_outs("beq_c2", 1'b0, 2'b10, 2'b10, 2'b00, 2'b00);
        step();
        bubble();
        check_outs("beq_c3", 1'b0, 2'b00, 2'b00, 2'b11, 2'b11);

        // jal ; jr $31: no stall, E forward in D, then M forward in E.
        drain();
        drive(1'b1, 5'd31, 2'd0, 5'd0, 2'd3, 5'd0, 2'd3);
        step();
        drive(1'b0, 5'd0, 2'd0, 5'd31, 2'd0, 5'd0, 2'd3);
        check_outs("jr_c1", 1'b0, 2'b01, 2'b00, 2'b00, 2'b00);
        step();
        bubble();
        check_outs("jr_c2", 1'b0, 2'b00, 2'b00, 2'b10, 2'b00);

        // lw $7 ; reader at t_use 0: two stalls, then W forward.
        drain();
        drive(1'b1, 5'd7, 2'd2, 5'd29, 2'd1, 5'd0, 2'd3);
        step();
        drive(1'b0, 5'd0, 2'd0, 5'd7, 2'd0, 5'd0, 2'd3);
        check_outs("lw0_c1", 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
        step();
        check_outs("lw0_c2", 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
        step();
        check_outs("lw0_c3", 1'b0, 2'b11, 2'b00, 2'b00, 2'b00);

        // add $12 ; reader rt=12 at t_use 1: no stall, M forward once in E.
        drain();
        drive(1'b1, 5'd12, 2'd1, 5'd1, 2'd1, 5'd2, 2'd1);
        step();
        drive(1'b1, 5'd13, 2'd1, 5'd0, 2'd3, 5'd12, 2'd1);
        check_outs("alu_e_c1", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        step();
        bubble();
        check_outs("alu_e_c2", 1'b0, 2'b00, 2'b00, 2'b00, 2'b10);

        // Writer of $0 never stalls or forwards.
        drain();
        drive(1'b1, 5'd0, 2'd2, 5'd29, 2'd1, 5'd0, 2'd3);
        step();
        drive(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
        check_outs("r0_c1", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        step();
        check_outs("r0_c2", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        step();
        check_outs("r0_c3", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);

        // lw $8 in flight, then a one-cycle reset pulse discards it.
        drain();
        drive(1'b1, 5'd8, 2'd2, 5'd29, 2'd1, 5'd0, 2'd3);
        step();
        drive(1'b0, 5'd0, 2'd0, 5'd8, 2'd1, 5'd0, 2'd3);
        check_outs("mid_pre", 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
        reset = 1'b0;
        #1;
        check_outs("mid_async", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        step();
        reset = 1'b1;
        #1;
        check_outs("mid_post1", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        step();
        bubble();
        check_outs("mid_post2", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        step();
        check_outs("mid_post3", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
